// File: rtl/uart_pkg.sv
// Shared UART definitions: frame states, parity selectors and line levels,
// used by both the transmit and the receive paths.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_t;

  localparam logic PAR_EVEN  = 1'b0;
  localparam logic PAR_ODD   = 1'b1;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/uart_tx_bit_timer.sv
// Bit-time counter: counts 0..eff_prescale-1 and flags the last cycle of each
// bit. The receive path's edge counter has the same shape.
module uart_tx_bit_timer #(
  parameter int PRESCALE_WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      restart,
  input  logic [PRESCALE_WIDTH-1:0] eff_prescale,
  output logic                      bit_done
);

  logic [PRESCALE_WIDTH-1:0] count;

  assign bit_done = (count == (eff_prescale - PRESCALE_WIDTH'(1)));

  // Counter wraps on the last cycle of a bit and is held at zero while restarting.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (restart) begin
      count <= '0;
    end else if (bit_done) begin
      count <= '0;
    end else begin
      count <= count + PRESCALE_WIDTH'(1);
    end
  end

endmodule

// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: valid/ready byte input, start + LSB-first data +
// optional parity + one stop bit, each bit held for max(prescale,1) clocks.
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int PRESCALE_WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [PRESCALE_WIDTH-1:0] prescale,
  input  logic                      par_en,
  input  logic                      par_typ,
  input  logic [DATA_WIDTH-1:0]     data_in,
  input  logic                      data_valid,
  output logic                      data_ready,
  output logic                      tx_out,
  output logic                      busy
);

  localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);

  function automatic logic parity_bit(input logic [DATA_WIDTH-1:0] d, input logic typ);
    return (^d) ^ (typ == PAR_ODD);
  endfunction

  uart_state_t               state;
  uart_state_t               next_state;
  logic [DATA_WIDTH-1:0]     data_l;
  logic                      par_en_l;
  logic                      par_typ_l;
  logic [PRESCALE_WIDTH-1:0] presc_l;
  logic [PRESCALE_WIDTH-1:0] eff_in;
  logic [IDX_W-1:0]          bit_idx;
  logic [IDX_W-1:0]          bit_idx_next;
  logic                      tx_next;
  logic                      bit_done;
  logic                      transfer;

  assign eff_in     = (prescale == '0) ? PRESCALE_WIDTH'(1) : prescale;
  assign data_ready = !rst && ((state == IDLE) || ((state == STOP) && bit_done));
  assign transfer   = data_valid && data_ready;

  uart_tx_bit_timer #(
    .PRESCALE_WIDTH(PRESCALE_WIDTH)
  ) u_bit_timer (
    .clk          (clk),
    .rst          (rst),
    .restart      (state == IDLE),
    .eff_prescale (presc_l),
    .bit_done     (bit_done)
  );

  // Next-state and data-bit index selection.
  always_comb begin
    next_state   = state;
    bit_idx_next = bit_idx;
    case (state)
      IDLE: begin
        if (transfer) next_state = START;
        else          next_state = IDLE;
      end
      START: begin
        if (bit_done) begin
          next_state   = DATA;
          bit_idx_next = '0;
        end else begin
          next_state = START;
        end
      end
      DATA: begin
        if (bit_done) begin
          if (bit_idx == LAST_IDX) begin
            next_state = par_en_l ? PARITY : STOP;
          end else begin
            bit_idx_next = bit_idx + IDX_W'(1);
          end
        end else begin
          next_state = DATA;
        end
      end
      PARITY: begin
        if (bit_done) next_state = STOP;
        else          next_state = PARITY;
      end
      STOP: begin
        if (bit_done) next_state = transfer ? START : IDLE;
        else          next_state = STOP;
      end
      default: next_state = IDLE;
    endcase
  end

  // Line level for the next cycle; registered below so tx_out never glitches.
  always_comb begin
    tx_next = STOP_BIT;
    case (next_state)
      IDLE:    tx_next = STOP_BIT;
      START:   tx_next = START_BIT;
      DATA:    tx_next = data_l[bit_idx_next];
      PARITY:  tx_next = parity_bit(data_l, par_typ_l);
      STOP:    tx_next = STOP_BIT;
      default: tx_next = STOP_BIT;
    endcase
  end

  // Frame state, outputs, and frame settings captured at each transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      bit_idx   <= '0;
      tx_out    <= STOP_BIT;
      busy      <= 1'b0;
      data_l    <= '0;
      par_en_l  <= 1'b0;
      par_typ_l <= PAR_EVEN;
      presc_l   <= PRESCALE_WIDTH'(1);
    end else begin
      state   <= next_state;
      bit_idx <= bit_idx_next;
      tx_out  <= tx_next;
      busy    <= (next_state != IDLE);
      if (transfer) begin
        data_l    <= data_in;
        par_en_l  <= par_en;
        par_typ_l <= par_typ;
        presc_l   <= eff_in;
      end else begin
        data_l    <= data_l;
        par_en_l  <= par_en_l;
        par_typ_l <= par_typ_l;
        presc_l   <= presc_l;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Directed self-checking bench for uart_tx_serializer; expected frames are
// written out by hand in transmit order (first bit sent is the leftmost).
module tb_uart_tx_serializer;

  logic       clk;
  logic       rst;
  logic [7:0] prescale;
  logic       par_en;
  logic       par_typ;
  logic [7:0] data_in;
  logic       data_valid;
  logic       data_ready;
  logic       tx_out;
  logic       busy;

  int checks   = 0;
  int failures = 0;

  uart_tx_serializer #(
    .DATA_WIDTH     (8),
    .PRESCALE_WIDTH (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .prescale   (prescale),
    .par_en     (par_en),
    .par_typ    (par_typ),
    .data_in    (data_in),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .tx_out     (tx_out),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge while idle: present a byte and let the next edge take it.
  task automatic start_tx(input logic [7:0] d, input logic [7:0] p, input logic pe, input logic pt);
    data_in    = d;
    prescale   = p;
    par_en     = pe;
    par_typ    = pt;
    data_valid = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string name);
    @(negedge clk);
    check($sformatf("%s idle tx_out", name), {7'd0, tx_out}, 8'd1);
    check($sformatf("%s idle busy", name), {7'd0, busy}, 8'd0);
    check($sformatf("%s idle data_ready", name), {7'd0, data_ready}, 8'd1);
  endtask

  // Checks every cycle of a frame that was accepted on the preceding edge.
  task automatic check_frame(input string name, input logic [11:0] bits, input int n,
                             input int p, input bit keep_valid, input bit disturb);
    for (int i = 0; i < n; i++) begin
      for (int c = 0; c < p; c++) begin
        @(negedge clk);
        check($sformatf("%s bit%0d cyc%0d tx_out", name, i, c), {7'd0, tx_out}, {7'd0, bits[n-1-i]});
        check($sformatf("%s bit%0d cyc%0d busy", name, i, c), {7'd0, busy}, 8'd1);
        check($sformatf("%s bit%0d cyc%0d data_ready", name, i, c), {7'd0, data_ready},
              {7'd0, (i == n-1) && (c == p-1)});
        if (disturb) begin
          data_in    = 8'($urandom);
          prescale   = 8'($urandom_range(0, 20));
          par_typ    = ~par_typ;
          par_en     = ~par_en;
          data_valid = (i == n-1) ? 1'b0 : ~data_valid;
        end else if (!keep_valid) begin
          data_valid = 1'b0;
        end else begin
          data_valid = 1'b1;
        end
      end
    end
  endtask

  initial begin
    rst        = 1'b1;
    prescale   = 8'd0;
    par_en     = 1'b0;
    par_typ    = 1'b0;
    data_in    = 8'h00;
    data_valid = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset tx_out", {7'd0, tx_out}, 8'd1);
    check("reset busy", {7'd0, busy}, 8'd0);
    check("reset data_ready", {7'd0, data_ready}, 8'd0);
    rst = 1'b0;
    check_idle("post_reset");

    // 0xA5, prescale 8, even parity
    start_tx(8'hA5, 8'd8, 1'b1, 1'b0);
    check_frame("a5_even", 12'b0_0101_0010_101, 11, 8, 1'b0, 1'b0);
    check_idle("a5_even");

    // 0x07, prescale 4, odd parity -> parity bit 0
    start_tx(8'h07, 8'd4, 1'b1, 1'b1);
    check_frame("07_odd", 12'b0_0111_0000_001, 11, 4, 1'b0, 1'b0);
    check_idle("07_odd");

    // 0x07, prescale 4, no parity -> 40-cycle frame
    start_tx(8'h07, 8'd4, 1'b0, 1'b1);
    check_frame("07_nopar", 12'b00_0111_0000_01, 10, 4, 1'b0, 1'b0);
    check_idle("07_nopar");

    // Back-to-back 0x55 then 0xAA at prescale 16, valid held high
    start_tx(8'h55, 8'd16, 1'b0, 1'b0);
    data_in = 8'hAA;
    check_frame("b2b_55", 12'b00_0101_0101_01, 10, 16, 1'b1, 1'b0);
    check_frame("b2b_aa", 12'b00_0010_1010_11, 10, 16, 1'b0, 1'b0);
    check_idle("b2b");

    // prescale 0 behaves as 1
    start_tx(8'hFF, 8'd0, 1'b0, 1'b0);
    check_frame("ff_p0", 12'b00_0111_1111_11, 10, 1, 1'b0, 1'b0);
    check_idle("ff_p0");

    // Reset during data bit 3 (0x35: bit3 = 0) of a prescale 8 frame
    start_tx(8'h35, 8'd8, 1'b1, 1'b0);
    data_valid = 1'b0;
    repeat (34) @(negedge clk);
    check("abort pre-reset tx_out", {7'd0, tx_out}, 8'd0);
    check("abort pre-reset busy", {7'd0, busy}, 8'd1);
    rst = 1'b1;
    @(negedge clk);
    check("abort reset tx_out", {7'd0, tx_out}, 8'd1);
    check("abort reset busy", {7'd0, busy}, 8'd0);
    check("abort reset data_ready", {7'd0, data_ready}, 8'd0);
    rst = 1'b0;
    check_idle("abort_release");
    start_tx(8'h3C, 8'd8, 1'b1, 1'b0);
    check_frame("3c_after_abort", 12'b0_0001_1110_001, 11, 8, 1'b0, 1'b0);
    check_idle("3c_after_abort");

    // Inputs churn mid-frame; 0x96 odd parity -> parity bit 1
    start_tx(8'h96, 8'd8, 1'b1, 1'b1);
    check_frame("96_disturb", 12'b0_0011_0100_111, 11, 8, 1'b0, 1'b1);
    check_idle("96_disturb");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_tx_serializer.md
Name: uart_tx_serializer

Overview:
UART transmit serializer, the transmit-side counterpart of the oversampled receive path.
- Accepts a parallel byte through a valid/ready handshake.
- Emits start bit, data LSB-first, optional parity and one stop bit on a registered serial line.
- Each bit lasts `prescale` clock cycles, so the same prescale value gives matching baud on both ends of the link.

Parameters:
DATA_WIDTH, 8, payload bits per frame
PRESCALE_WIDTH, 8, width of the prescale input and the bit-time counter

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
prescale  input  PRESCALE_WIDTH  clock cycles per bit; 0 is treated as 1
par_en  input  1  1 = insert parity bit
par_typ  input  1  0 = even parity, 1 = odd parity
data_in  input  DATA_WIDTH  byte to send
data_valid  input  1  data_in is valid
data_ready  output  1  block can accept a byte this cycle (combinational)
tx_out  output  1  serial line, registered, idles high
busy  output  1  frame in progress, registered

Behaviour:
- Clocking: one clock (clk); reset is synchronous and active-high (rst). On rst: state IDLE, tx_out=1, busy=0, all counters 0. A reset mid-frame aborts the frame, and tx_out is 1 after that edge.
- States: IDLE, START, DATA, PARITY, STOP.
- Handshake:
  - data_ready=1 in IDLE, and in STOP on its last cycle (bit counter == eff_prescale-1). It is 0 otherwise, and 0 while rst=1.
  - A transfer occurs on a clk edge with data_valid && data_ready.
  - At transfer, data_in, par_en, par_typ and eff_prescale=max(prescale,1) are latched. Input changes mid-frame have no effect.
- Latency: tx_out drives the start bit 0 in the cycle after the transfer edge; busy rises at the same edge.
- Bit timing:
  - A bit counter counts 0..eff_prescale-1. Each bit is held for exactly eff_prescale cycles.
  - The state advances when the counter wraps; the counter resets to 0 on every bit change.
- Transitions:
  - IDLE→START on transfer.
  - START→DATA.
  - DATA emits bits 0..DATA_WIDTH-1 using a bit index counter; after the last bit, go to PARITY if par_en else STOP.
  - PARITY→STOP.
  - STOP→START if a transfer happens on its last cycle (back-to-back, no idle gap), else IDLE.
- Parity bit: XOR of the latched data when even; inverted XOR when odd.
- Frame length: (DATA_WIDTH+2+par_en)*eff_prescale cycles.
- busy: 1 from the transfer edge until the edge that enters IDLE. It stays 1 across back-to-back frames.
- Glitch rule: tx_out is taken directly from a flop; no combinational path from inputs to tx_out.
- data_valid while data_ready=0 is ignored. No error flag is raised; the sender must hold data until ready.

Decomposition:
- Shared package uart_pkg:
  - state enum (IDLE/START/DATA/PARITY/STOP)
  - parity-type constants PAR_EVEN=0, PAR_ODD=1
  - line-level constants for START_BIT=0, STOP_BIT=1
  - the same package also serves the receive side.
- One sub-module, uart_tx_bit_timer:
  - Loadable counter that takes eff_prescale and a restart strobe, and outputs bit_done (last cycle of the bit).
  - The receive path's edge counter has the same shape and can reuse it.

Test Plan:
1. prescale=8, par_en=1, par_typ=0, data=0xA5 → tx_out sequence 0,1,0,1,0,0,1,0,1,0,1, each held 8 cycles; 88 cycles total; busy high throughout; data_ready high again on the last stop cycle.
2. prescale=4, par_en=1, par_typ=1, data=0x07 → parity bit 0 (three ones, odd); par_en=0 with the same data → no parity slot, 40-cycle frame.
3. prescale=16, two bytes 0x55 then 0xAA with data_valid held continuously → second start bit begins the cycle after the first stop bit's 16th cycle; busy never drops between frames.
4. prescale=0, data=0xFF, par_en=0 → each bit lasts 1 cycle; frame = 0,1×8,1 over 10 cycles.
5. rst asserted during data bit 3 of a prescale=8 frame → tx_out=1, busy=0, data_ready=1 on the next edge after rst deasserts; a new byte then sends a complete, correct frame.
6. data_in, prescale and par_typ changed mid-frame while data_valid pulses → frame unaffected, new byte not accepted until data_ready.
